// File: rtl/mult_wb_arbiter.sv
// Shares the register-file write port between MEM/WB writeback and the multiplier result stream.
// Buffers results that lose arbitration and raises credit/RAW/WAW stalls toward ID.
module mult_wb_arbiter #(
    parameter int unsigned MULT_PPL_STAGE = 4,
    parameter int unsigned BUF_DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   mult_rd_addr_i,
    input  logic [31:0]                  mult_rd_data_i,
    input  logic [31:0]                  mult_flags_i,
    input  logic                         mult_issue_i,
    input  logic                         wb_we_i,
    input  logic [4:0]                   wb_addr_i,
    input  logic [31:0]                  wb_data_i,
    input  logic [4:0]                   id_rs1_addr_i,
    input  logic [4:0]                   id_rs2_addr_i,
    input  logic [4:0]                   id_rd_addr_i,
    input  logic                         id_rd_we_i,
    output logic                         rf_we_o,
    output logic [4:0]                   rf_waddr_o,
    output logic [31:0]                  rf_wdata_o,
    output logic                         stall_o,
    output logic [31:0]                  pending_flags_o,
    output logic [$clog2(BUF_DEPTH):0]   buf_count_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned IW = $clog2(BUF_DEPTH + MULT_PPL_STAGE) + 1;

    logic [4:0]    addr_q [BUF_DEPTH];
    logic [31:0]   data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] valid_q;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] inflight_q;

    logic          mult_valid, wb_win, buf_empty;
    logic          pop, direct, push, issue_ok;
    logic          credit_stall, raw_stall, waw_stall;
    logic [31:0]   credit_sum;
    logic [31:0]   pend;

    assign mult_valid = (mult_rd_addr_i != 5'd0);
    assign wb_win     = wb_we_i && (wb_addr_i != 5'd0);
    assign buf_empty  = (count_q == '0);
    // Buffered/in-flight results are discarded by reset, so they must not write while it is held.
    assign pop        = !rst && !wb_win && !buf_empty;
    assign direct     = !rst && !wb_win && buf_empty && mult_valid;
    assign push       = mult_valid && !direct;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (wb_win) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_addr_i;
            rf_wdata_o = wb_data_i;
        end else if (pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = addr_q[head_q];
            rf_wdata_o = data_q[head_q];
        end else if (direct) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = mult_rd_addr_i;
            rf_wdata_o = mult_rd_data_i;
        end
    end

    always_comb begin
        pend = mult_flags_i;
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            if (valid_q[i]) begin
                pend[addr_q[i]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    assign pending_flags_o = pend;
    assign buf_count_o     = count_q;

    assign credit_sum   = 32'(count_q) + 32'(inflight_q);
    assign credit_stall = mult_issue_i && (credit_sum >= BUF_DEPTH);
    assign raw_stall    = ((id_rs1_addr_i != 5'd0) && pend[id_rs1_addr_i]) ||
                          ((id_rs2_addr_i != 5'd0) && pend[id_rs2_addr_i]);
    assign waw_stall    = id_rd_we_i && (id_rd_addr_i != 5'd0) && pend[id_rd_addr_i];
    assign stall_o      = credit_stall || raw_stall || waw_stall;
    assign issue_ok     = mult_issue_i && !stall_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            assert (!(push && !pop && (count_q == CW'(BUF_DEPTH))));
            if (push) begin
                addr_q[tail_q]  <= mult_rd_addr_i;
                data_q[tail_q]  <= mult_rd_data_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= (tail_q == PW'(BUF_DEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= (head_q == PW'(BUF_DEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            // Decrement saturates so a stray result cannot wrap the credit counter.
            if (issue_ok && !(mult_valid && inflight_q != '0)) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (!issue_ok && mult_valid && inflight_q != '0) begin
                inflight_q <= inflight_q - 1'b1;
            end
        end
    end

endmodule

// File: doc/mult_wb_arbiter.md
Name: mult_wb_arbiter

Overview:
- Receiving end of the multiplier result stream. It accepts the rd_addr/rd_data pair that emerges from the multiplier pipeline.
- It shares the single register-file write port with the main MEM/WB writeback, and buffers multiplier results that lose arbitration.
- The multiplier pipeline cannot stall. This block therefore issues credit-based issue stalls and RAW/WAW hazard stalls to the ID stage.

Parameters:
- MULT_PPL_STAGE, 4, multiplier pipeline depth in cycles. It must match the multiplier manager's stage count.
- BUF_DEPTH, 4, number of result-buffer entries. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mult_rd_addr_i  input  5  destination register of the result exiting the multiplier this cycle; 0 means no result
- mult_rd_data_i  input  32  multiplier result data
- mult_flags_i  input  32  one-hot-per-register in-flight destinations reported by the multiplier manager
- mult_issue_i  input  1  ID stage holds a multiply with rd != 0
- wb_we_i  input  1  main pipeline writeback enable
- wb_addr_i  input  5  main writeback register
- wb_data_i  input  32  main writeback data
- id_rs1_addr_i  input  5  ID source 1
- id_rs2_addr_i  input  5  ID source 2
- id_rd_addr_i  input  5  ID destination
- id_rd_we_i  input  1  ID instruction writes rd via the main pipeline (non-multiply)
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  register-file write address
- rf_wdata_o  output  32  register-file write data
- stall_o  output  1  hold the ID stage
- pending_flags_o  output  32  mult_flags_i OR'd with all valid buffer-entry destinations; bit 0 forced 0
- buf_count_o  output  log2(BUF_DEPTH)+1  valid buffer entries

Behaviour:
- Reset (synchronous): buffer empty, head/tail pointers 0, inflight counter 0, buf_count_o = 0.
  - With idle inputs, all outputs are 0 during and after reset.
  - Reset mid-operation discards buffered and in-flight results; no write is emitted for them.
- Write-port arbitration (combinational outputs, decided each cycle):
  - Priority 1: wb_we_i=1 with wb_addr_i != 0 writes the main data.
  - Priority 2: otherwise, if the buffer is non-empty, write the head entry and pop it.
  - Priority 3: otherwise, if mult_rd_addr_i != 0, write the incoming result directly.
  - Otherwise rf_we_o = 0.
- Buffer push: an incoming result with mult_rd_addr_i != 0 is pushed at the tail unless it was written directly this cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Results are written in arrival order; the head always drains before any newer result.
  - Pointers wrap modulo BUF_DEPTH.
- Inflight counter: +1 when mult_issue_i & ~stall_o; −1 when mult_rd_addr_i != 0. Simultaneous +1/−1 leaves it unchanged.
- Credit stall: asserted when mult_issue_i and (buf_count + inflight) >= BUF_DEPTH. Buffer overflow is therefore impossible.
  - Overflow is an assertion failure, not a handled case.
- RAW stall: a nonzero id_rs1_addr_i or id_rs2_addr_i whose bit is set in pending_flags_o. No forwarding from this block.
- WAW stall: id_rd_we_i with nonzero id_rd_addr_i whose bit is set in pending_flags_o. This prevents an older multiply result overwriting a younger ALU/load result.
- stall_o = credit | RAW | WAW. It is purely combinational from inputs and registered state.
- The stall releases in the cycle after the matching entry's register-file write. pending_flags_o drops the bit once the pop or direct write has occurred.
- Register x0: never written and never flagged; mult_rd_addr_i = 0 is not a result.

Test Plan:
- Idle port: result (addr 5, 0x1234) arrives with wb_we_i=0 → same-cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; buf_count_o stays 0.
- Conflict: result (7, 0xAA) arrives while wb writes (3, 0xBB) → rf writes 3/0xBB and buf_count_o=1. Next cycle with wb idle → rf writes 7/0xAA and buf_count_o=0.
- RAW: result for x9 buffered behind a busy port; ID rs1=9 → stall_o=1 until the cycle after the x9 write, then 0. With rs2=0 and x0 flagged in the input, no stall occurs.
- Credit: BUF_DEPTH=4 with wb_we_i held 1 → four issues accepted, then the fifth issue sees stall_o=1. The count never exceeds 4, and the stall drops after the first pop.
- WAW: mult to x4 in flight (mult_flags_i bit 4); ID non-mult writing x4 → stall_o=1 until x4 is committed from the multiplier.
- Reset with 3 buffered entries and 2 in flight → next cycle buf_count_o=0 and pending_flags_o reflects only mult_flags_i. No rf write is emitted for discarded entries, and a subsequent issue is not credit-stalled.
